// File: rtl/apb_mem_slave.sv
// APB3 completer backed by a byte-wide register file with WAIT_CYCLES wait states.
// Optional error response is enabled with the APB_SLV_ERR_EN macro.
module apb_mem_slave #(
  parameter int AW          = 9,
  parameter int DW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [AW-1:0] PADDR,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q;
  logic [IW-1:0] idx_q;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic          setup, complete;
  logic          addr_err;
  logic [DW-1:0] mem [DEPTH];

  // The top address bit selects between slaves upstream and carries no meaning here.
  logic unused_decode_bit;
  assign unused_decode_bit = PADDR[AW-1];

  assign addr_err = int'(PADDR[AW-2:0]) >= DEPTH;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    setup    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          setup   = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL || !PENABLE) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd0) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      PRDATA  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        wcnt_q <= 4'(WAIT_CYCLES);
        err_q  <= addr_err;
        PRDATA <= (PWRITE || addr_err) ? '0 : mem[PADDR[IW-1:0]];
      end else if (state_q == ACCESS && wcnt_q != 4'd0) begin
        wcnt_q <= wcnt_q - 4'd1;
      end
    end
  end

  // Transfer fields are captured once at setup; bus changes during ACCESS are ignored.
  always_ff @(posedge PCLK) begin
    if (setup) begin
      idx_q   <= PADDR[IW-1:0];
      wr_q    <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

  // NOTE: the register file has no reset; only the commit is gated so a reset discards a pending write.
  always_ff @(posedge PCLK) begin
    if (PRESETn && complete && wr_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign PREADY = (state_q == ACCESS) && (wcnt_q == 4'd0);

`ifdef APB_SLV_ERR_EN
  assign PSLVERR = PREADY && err_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (no waits / full depth, 3 waits / half depth)
// checked against an array model of the register file.
module tb_apb_mem_slave;

  localparam int W0 = 0;
  localparam int D0 = 256;
  localparam int W1 = 3;
  localparam int D1 = 128;
`ifdef APB_SLV_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       pclk    = 1'b0;
  logic       presetn = 1'b0;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [8:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
  logic       pslverr [2];

  int total = 0;
  int bad   = 0;
  logic [7:0] model [2][256];

  always #5 pclk = ~pclk;

  apb_mem_slave #(.AW(9), .DW(8), .DEPTH(D0), .WAIT_CYCLES(W0)) u_fast (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.AW(9), .DW(8), .DEPTH(D1), .WAIT_CYCLES(W1)) u_slow (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  function automatic int wait_of(input int w);
    return (w == 0) ? W0 : W1;
  endfunction

  function automatic int depth_of(input int w);
    return (w == 0) ? D0 : D1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Drives one transfer starting at the current cycle; returns one cycle after it ends.
  task automatic xfer(input int w, input bit wr, input logic [8:0] a, input logic [7:0] d,
                      input int abort_at, input bit scramble,
                      output logic [7:0] rd, output logic slv, output int waits, output bit done);
    psel[w] = 1'b1; penable[w] = 1'b0; pwrite[w] = wr; paddr[w] = a; pwdata[w] = d;
    tick();
    penable[w] = 1'b1;
    waits = 0; done = 1'b0; rd = 8'h00; slv = 1'b0;
    forever begin
      if (pready[w] === 1'b1) begin
        rd = prdata[w]; slv = pslverr[w]; done = 1'b1;
        tick();
        break;
      end
      if (waits == abort_at) begin
        psel[w] = 1'b0; penable[w] = 1'b0;
        tick();
        break;
      end
      if (waits >= 20) begin
        check($sformatf("timeout u%0d", w), 32'(waits), 32'(wait_of(w)));
        break;
      end
      if (scramble) begin
        pwrite[w] = 1'($urandom); paddr[w] = 9'($urandom); pwdata[w] = 8'($urandom);
      end
      waits++;
      tick();
    end
    psel[w] = 1'b0; penable[w] = 1'b0;
  endtask

  task automatic op(input int w, input bit wr, input logic [8:0] a, input logic [7:0] d,
                    input bit scramble, output logic [7:0] rd_o);
    logic [7:0] rd, exp;
    logic       slv;
    int         waits;
    bit         done, err;
    string      id;
    err = int'(a[7:0]) >= depth_of(w);
    exp = (wr || err) ? 8'h00 : model[w][a[7:0]];
    id  = $sformatf("u%0d %s @%03h", w, wr ? "wr" : "rd", a);
    xfer(w, wr, a, d, -1, scramble, rd, slv, waits, done);
    check({"done ", id},   32'(done),  32'd1);
    check({"waits ", id},  32'(waits), 32'(wait_of(w)));
    check({"slverr ", id}, 32'(slv),   32'(ERR_EN && err));
    check({"rdata ", id},  32'(rd),    32'(exp));
    if (wr && !err) model[w][a[7:0]] = d;
    rd_o = rd;
  endtask

  initial begin
    logic [7:0] rd, slv_rd;
    logic       slv;
    int         waits;
    bit         done;
    int         w;
    logic [8:0] a;

    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
    end

    // Reset held for two edges
    presetn = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst pready u%0d", i),  32'(pready[i]),  32'd0);
      check($sformatf("rst prdata u%0d", i),  32'(prdata[i]),  32'd0);
      check($sformatf("rst pslverr u%0d", i), 32'(pslverr[i]), 32'd0);
    end
    presetn = 1'b1;
    tick();

    // Access phase without a setup phase is ignored
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 9'h005;
    repeat (2) begin
      tick();
      check("no-setup pready u0", 32'(pready[0]), 32'd0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    tick();

    // Fill both register files so every later read has a known model value
    for (int i = 0; i < D0; i++) op(0, 1'b1, 9'(i) | 9'($urandom_range(0, 1) << 8), 8'($urandom), 1'b0, rd);
    for (int i = 0; i < D1; i++) op(1, 1'b1, 9'(i) | 9'($urandom_range(0, 1) << 8), 8'($urandom), 1'b0, rd);

    // Zero-wait write then read, and PRDATA hold after completion
    op(0, 1'b1, 9'h0A5, 8'h3C, 1'b0, rd);
    op(0, 1'b0, 9'h0A5, 8'h00, 1'b0, rd);
    check("read 0A5 value", 32'(rd), 32'h3C);
    check("prdata hold 1", 32'(prdata[0]), 32'h3C);
    tick();
    check("prdata hold 2", 32'(prdata[0]), 32'h3C);

    // Wait-state read, with bus scrambling during the waits
    op(1, 1'b0, 9'h010, 8'h00, 1'b1, rd);

    // Out-of-range write and read on the half-depth instance
    op(1, 1'b1, 9'h0F0, 8'h55, 1'b0, rd);
    op(1, 1'b0, 9'h070, 8'h00, 1'b0, rd);
    op(1, 1'b0, 9'h0F0, 8'h00, 1'b0, rd);

    // Abort after one wait cycle leaves memory untouched
    op(1, 1'b1, 9'h020, 8'h11, 1'b0, rd);
    xfer(1, 1'b1, 9'h020, 8'h99, 1, 1'b0, rd, slv, waits, done);
    check("abort done", 32'(done), 32'd0);
    check("abort pready idle", 32'(pready[1]), 32'd0);
    tick();
    op(1, 1'b0, 9'h020, 8'h00, 1'b0, rd);
    check("read 020 after abort", 32'(rd), 32'h11);

    // Reset in the middle of a write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h030; pwdata[1] = 8'h77;
    tick();
    penable[1] = 1'b1;
    tick();
    presetn = 1'b0;
    tick();
    check("midrst pready",  32'(pready[1]),  32'd0);
    check("midrst prdata",  32'(prdata[1]),  32'd0);
    check("midrst pslverr", 32'(pslverr[1]), 32'd0);
    presetn = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
    tick();
    op(1, 1'b0, 9'h030, 8'h00, 1'b0, rd);

    // Back-to-back write/read with no idle cycle
    for (int i = 0; i < 2; i++) begin
      op(i, 1'b1, 9'h040, 8'hA0 + 8'(i), 1'b0, rd);
      op(i, 1'b0, 9'h040, 8'h00, 1'b0, rd);
      check($sformatf("b2b read u%0d", i), 32'(rd), 32'hA0 + 32'(i));
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      w = n % 2;
      a = 9'($urandom);
      if (w == 1 && $urandom_range(0, 7) == 0) begin
        xfer(1, 1'($urandom), a, 8'($urandom), $urandom_range(0, 2), 1'b1, slv_rd, slv, waits, done);
        check("rand abort done", 32'(done), 32'd0);
      end else begin
        op(w, 1'($urandom), a, 8'($urandom), w == 1, rd);
      end
      if ($urandom_range(0, 1) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
